// File: rtl/multi_gate_reducer_pkg.sv
// rtl/multi_gate_reducer_pkg.sv - mode, base-op and FSM encodings for the gate reducer
package gate_reducer_pkg;

    localparam logic [2:0] MODE_AND  = 3'd0;
    localparam logic [2:0] MODE_OR   = 3'd1;
    localparam logic [2:0] MODE_XOR  = 3'd2;
    localparam logic [2:0] MODE_NAND = 3'd3;
    localparam logic [2:0] MODE_NOR  = 3'd4;
    localparam logic [2:0] MODE_XNOR = 3'd5;

    typedef enum logic [1:0] {
        OP_AND = 2'd0,
        OP_OR  = 2'd1,
        OP_XOR = 2'd2
    } base_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    function automatic base_op_t mode_to_base(input logic [2:0] mode);
        case (mode)
            MODE_OR, MODE_NOR:   return OP_OR;
            MODE_XOR, MODE_XNOR: return OP_XOR;
            default:             return OP_AND;
        endcase
    endfunction

    function automatic logic mode_inverts(input logic [2:0] mode);
        return (mode == MODE_NAND) || (mode == MODE_NOR) || (mode == MODE_XNOR);
    endfunction

    function automatic logic mode_identity(input logic [2:0] mode);
        return (mode == MODE_AND) || (mode == MODE_NAND);
    endfunction

    function automatic logic mode_reserved(input logic [2:0] mode);
        return mode > MODE_XNOR;
    endfunction

endpackage

// File: rtl/multi_gate_reducer_chunk_reduce.sv
// rtl/multi_gate_reducer_chunk_reduce.sv - folds one CHUNK-bit slice into the accumulator
module chunk_reduce
    import gate_reducer_pkg::*;
#(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] slice,
    input  logic             acc_in,
    input  base_op_t         op,
    output logic             acc_out
);

    always_comb begin
        acc_out = acc_in;
        case (op)
            OP_AND:  acc_out = acc_in & (&slice);
            OP_OR:   acc_out = acc_in | (|slice);
            OP_XOR:  acc_out = acc_in ^ (^slice);
            default: acc_out = acc_in;
        endcase
    end

endmodule

// File: rtl/multi_gate_reducer.sv
// rtl/multi_gate_reducer.sv - serial WIDTH-bit reduction unit with valid/ready handshakes
module multi_gate_reducer
    import gate_reducer_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [2:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_y,
    output logic             out_err,
    output logic             busy
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    if (WIDTH < 1 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
        $error("multi_gate_reducer: illegal WIDTH/CHUNK combination");
    end

    state_t           state, state_nxt;
    logic [WIDTH-1:0] data_q;
    logic [2:0]       mode_q;
    logic             acc;
    logic             acc_nxt;
    logic [CW-1:0]    cnt;
    logic [CHUNK-1:0] chunk_slice;
    logic             last_chunk;

    assign chunk_slice = data_q[CHUNK*int'(cnt) +: CHUNK];
    assign last_chunk  = (cnt == CW'(NCHUNK - 1));

    chunk_reduce #(.CHUNK(CHUNK)) u_chunk_reduce (
        .slice   (chunk_slice),
        .acc_in  (acc),
        .op      (mode_to_base(mode_q)),
        .acc_out (acc_nxt)
    );

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (last_chunk) state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // out_y/out_err are cleared on accept so a stale error never leaks into the next result
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            data_q  <= '0;
            mode_q  <= '0;
            acc     <= 1'b0;
            cnt     <= '0;
            out_y   <= 1'b0;
            out_err <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        data_q  <= in_data;
                        mode_q  <= in_mode;
                        acc     <= mode_identity(in_mode);
                        cnt     <= '0;
                        out_y   <= 1'b0;
                        out_err <= 1'b0;
                    end
                end
                ST_RUN: begin
                    acc <= acc_nxt;
                    if (last_chunk) begin
                        cnt     <= '0;
                        out_y   <= mode_reserved(mode_q) ? 1'b0 : (acc_nxt ^ mode_inverts(mode_q));
                        out_err <= mode_reserved(mode_q);
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_gate_reducer.sv
// tb/tb_multi_gate_reducer.sv - randomized self-checking bench for multi_gate_reducer
module tb_multi_gate_reducer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, out_y, out_err, busy;
    logic [15:0] in_data;
    logic [2:0]  in_mode;

    logic        s_in_valid, s_out_ready;
    logic [3:0]  s_in_data;
    logic [2:0]  s_in_mode;
    logic        a_in_ready, a_out_valid, a_out_y, a_out_err, a_busy;
    logic        b_in_ready, b_out_valid, b_out_y, b_out_err, b_busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    multi_gate_reducer #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid),
        .out_ready(out_ready), .out_y(out_y), .out_err(out_err), .busy(busy)
    );

    multi_gate_reducer #(.WIDTH(4), .CHUNK(1)) dut_a (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(a_in_ready),
        .in_data(s_in_data), .in_mode(s_in_mode), .out_valid(a_out_valid),
        .out_ready(s_out_ready), .out_y(a_out_y), .out_err(a_out_err), .busy(a_busy)
    );

    multi_gate_reducer #(.WIDTH(4), .CHUNK(4)) dut_b (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(b_in_ready),
        .in_data(s_in_data), .in_mode(s_in_mode), .out_valid(b_out_valid),
        .out_ready(s_out_ready), .out_y(b_out_y), .out_err(b_out_err), .busy(b_busy)
    );

    // Reference: count ones over the low w bits and apply the mode's rule directly
    function automatic logic ref_y(input int w, input logic [15:0] d, input logic [2:0] m);
        logic [15:0] v;
        int ones;
        v    = d & 16'((32'h1 << w) - 1);
        ones = $countones(v);
        case (m)
            3'd0:    return ones == w;
            3'd1:    return ones != 0;
            3'd2:    return (ones % 2) == 1;
            3'd3:    return ones != w;
            3'd4:    return ones == 0;
            3'd5:    return (ones % 2) == 0;
            default: return 1'b0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic [15:0] d, input logic [2:0] m,
                          output logic y, output logic err, output int lat);
        int guard = 0;
        while (!in_ready && guard < 20) begin
            tick();
            guard++;
        end
        in_valid = 1'b1;
        in_data  = d;
        in_mode  = m;
        tick();
        in_valid = 1'b0;
        in_data  = 16'($urandom);
        in_mode  = 3'($urandom);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!out_valid && lat < 20);
        y   = out_y;
        err = out_err;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total += 5;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        if (out_y !== 1'b0) begin bad++; $display("FAIL reset_out_y got=%b exp=0", out_y); end
        if (out_err !== 1'b0) begin bad++; $display("FAIL reset_out_err got=%b exp=0", out_err); end
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_and_latency();
        logic y, err;
        int lat;
        do_req(16'hFFFF, 3'd0, y, err, lat);
        total += 2;
        if (lat !== 4) begin bad++; $display("FAIL and_latency got=%0d exp=4", lat); end
        if (y !== 1'b1) begin bad++; $display("FAIL and_ffff got=%b exp=1", y); end
        do_req(16'hFFFE, 3'd0, y, err, lat);
        total += 1;
        if (y !== 1'b0) begin bad++; $display("FAIL and_fffe got=%b exp=0", y); end
    endtask

    task automatic test_modes();
        logic [15:0] dv [6] = '{16'h0000, 16'h8000, 16'h0001, 16'h0003, 16'hFFFF, 16'h0000};
        logic [2:0]  mv [6] = '{3'd1, 3'd1, 3'd2, 3'd5, 3'd3, 3'd4};
        logic        ev [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic y, err;
        int lat;
        for (int i = 0; i < 6; i++) begin
            do_req(dv[i], mv[i], y, err, lat);
            total += 3;
            if (y !== ev[i]) begin bad++; $display("FAIL mode%0d_y data=%h got=%b exp=%b", mv[i], dv[i], y, ev[i]); end
            if (err !== 1'b0) begin bad++; $display("FAIL mode%0d_err got=%b exp=0", mv[i], err); end
            if (lat !== 4) begin bad++; $display("FAIL mode%0d_latency got=%0d exp=4", mv[i], lat); end
        end
    endtask

    task automatic test_random();
        logic [15:0] d;
        logic [2:0]  m;
        logic y, err;
        int lat;
        for (int i = 0; i < 40; i++) begin
            d = 16'($urandom);
            m = 3'($urandom_range(0, 7));
            if (i % 4 == 0) d = (i % 8 == 0) ? 16'hFFFF : 16'h0000;
            do_req(d, m, y, err, lat);
            total += 3;
            if (y !== ref_y(16, d, m)) begin bad++; $display("FAIL random_y data=%h mode=%0d got=%b exp=%b", d, m, y, ref_y(16, d, m)); end
            if (err !== (m > 3'd5)) begin bad++; $display("FAIL random_err mode=%0d got=%b exp=%b", m, err, m > 3'd5); end
            if (lat !== 4) begin bad++; $display("FAIL random_latency got=%0d exp=4", lat); end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] d;
        logic exp_y;
        int guard = 0;
        d = 16'h1234;
        exp_y = ref_y(16, d, 3'd2);
        in_valid = 1'b1;
        in_data  = d;
        in_mode  = 3'd2;
        tick();
        in_valid = 1'b0;
        while (!out_valid && guard < 20) begin
            tick();
            guard++;
        end
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'($urandom);
            in_data  = 16'($urandom);
            in_mode  = 3'($urandom);
            tick();
            total += 3;
            if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_out_valid cyc=%0d got=%b exp=1", i, out_valid); end
            if (out_y !== exp_y) begin bad++; $display("FAIL bp_out_y cyc=%0d got=%b exp=%b", i, out_y, exp_y); end
            if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", i, in_ready); end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total += 2;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_in_ready got=%b exp=1", in_ready); end
        if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_release_out_valid got=%b exp=0", out_valid); end
        for (int i = 0; i < 6; i++) begin
            tick();
            total++;
            if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_no_second_result cyc=%0d got=%b exp=0", i, out_valid); end
        end
    endtask

    task automatic test_reserved();
        logic y, err;
        int lat;
        do_req(16'hFFFF, 3'd7, y, err, lat);
        total += 3;
        if (lat !== 4) begin bad++; $display("FAIL reserved_latency got=%0d exp=4", lat); end
        if (y !== 1'b0) begin bad++; $display("FAIL reserved_y got=%b exp=0", y); end
        if (err !== 1'b1) begin bad++; $display("FAIL reserved_err got=%b exp=1", err); end
        do_req(16'h00F0, 3'd1, y, err, lat);
        total += 2;
        if (err !== 1'b0) begin bad++; $display("FAIL reserved_clear_err got=%b exp=0", err); end
        if (y !== 1'b1) begin bad++; $display("FAIL reserved_next_y got=%b exp=1", y); end
    endtask

    task automatic test_reset_mid();
        logic y, err;
        int lat;
        in_valid = 1'b1;
        in_data  = 16'hFFFF;
        in_mode  = 3'd0;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total += 3;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_out_valid got=%b exp=0", out_valid); end
        if (in_ready !== 1'b1) begin bad++; $display("FAIL midrst_in_ready got=%b exp=1", in_ready); end
        if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        for (int i = 0; i < 6; i++) begin
            tick();
            total++;
            if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_partial cyc=%0d got=%b exp=0", i, out_valid); end
        end
        do_req(16'hFFFF, 3'd0, y, err, lat);
        total += 2;
        if (y !== 1'b1) begin bad++; $display("FAIL midrst_next_y got=%b exp=1", y); end
        if (lat !== 4) begin bad++; $display("FAIL midrst_next_latency got=%0d exp=4", lat); end
    endtask

    task automatic test_exhaustive();
        int la, lb;
        logic ya, yb, e;
        for (int m = 0; m < 6; m++) begin
            for (int d = 0; d < 16; d++) begin
                total++;
                if (!(a_in_ready && b_in_ready)) begin bad++; $display("FAIL exh_idle a=%b b=%b exp=1", a_in_ready, b_in_ready); end
                s_in_valid = 1'b1;
                s_in_data  = 4'(d);
                s_in_mode  = 3'(m);
                tick();
                s_in_valid = 1'b0;
                s_in_data  = 4'($urandom);
                la = 0; lb = 0; ya = 1'bx; yb = 1'bx;
                for (int c = 1; c <= 6; c++) begin
                    tick();
                    if (a_out_valid && la == 0) begin la = c; ya = a_out_y; end
                    if (b_out_valid && lb == 0) begin lb = c; yb = b_out_y; end
                end
                e = ref_y(4, 16'(d), 3'(m));
                total += 4;
                if (la !== 4) begin bad++; $display("FAIL exh_c1_latency m=%0d d=%0d got=%0d exp=4", m, d, la); end
                if (lb !== 1) begin bad++; $display("FAIL exh_c4_latency m=%0d d=%0d got=%0d exp=1", m, d, lb); end
                if (ya !== e) begin bad++; $display("FAIL exh_c1_y m=%0d d=%0d got=%b exp=%b", m, d, ya, e); end
                if (yb !== e) begin bad++; $display("FAIL exh_c4_y m=%0d d=%0d got=%b exp=%b", m, d, yb, e); end
                s_out_ready = 1'b1;
                tick();
                s_out_ready = 1'b0;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; in_data = '0; in_mode = '0;
        s_in_valid = 1'b0; s_out_ready = 1'b0; s_in_data = '0; s_in_mode = '0;
        test_reset();
        test_and_latency();
        test_modes();
        test_backpressure();
        test_reserved();
        test_reset_mid();
        test_random();
        test_exhaustive();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multi_gate_reducer.md
Name: multi_gate_reducer

Overview:
- Parametrised successor to the fixed 4-input AND gate: reduces a WIDTH-bit operand to one bit using a selectable logic function (AND/OR/XOR/NAND/NOR/XNOR).
- Processes the operand serially, CHUNK bits per cycle, under an FSM with valid/ready handshakes on input and output.
- Sits between a request producer and a result consumer as a reusable, area-scalable reduction unit.

Parameters:
- WIDTH, 16, operand width in bits; must be >= 1.
- CHUNK, 4, bits reduced per cycle; 1 <= CHUNK <= WIDTH; WIDTH % CHUNK == 0 (elaboration-time check, $error otherwise).
- NCHUNK (localparam), WIDTH/CHUNK, cycles per reduction.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- in_data  in  WIDTH  operand.
- in_mode  in  3  0=AND 1=OR 2=XOR 3=NAND 4=NOR 5=XNOR 6,7=reserved.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_y  out  1  reduction result.
- out_err  out  1  request used a reserved mode.
- busy  out  1  state != IDLE.

Behaviour:
- Single clock (clk); reset is synchronous and active-high (rst), sampled on the rising edge of clk.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_y=0, out_err=0, busy=0, cnt=0, acc=0.
- FSM states: IDLE, RUN, HOLD.
  - IDLE: in_ready=1. On in_valid&in_ready, latch in_data and in_mode, set acc to the identity (1 for AND/NAND, 0 for OR/NOR/XOR/XNOR), set cnt=0, go to RUN.
  - RUN: in_ready=0. Each cycle fold chunk in_data_q[cnt*CHUNK +: CHUNK] into acc with the base op (AND/OR/XOR), then cnt++. On the edge that processes chunk NCHUNK-1, register out_y = acc_final XOR invert (invert=1 for NAND/NOR/XNOR), set out_valid=1, go to HOLD.
  - HOLD: out_valid=1; out_y and out_err are stable. On out_ready, clear out_valid and go to IDLE.
- in_ready=0 in HOLD. No same-cycle accept of a new request while a result is pending.
- Latency: if the handshake occurs at edge k, out_valid is high after edge k+NCHUNK. Throughput is one result per NCHUNK+2 cycles minimum.
- CHUNK==WIDTH: RUN lasts one cycle (NCHUNK=1).
- Reserved modes 6 and 7: the request is accepted and takes the normal latency, with out_y=0 and out_err=1. out_err is 0 for every valid mode.
- in_data and in_mode changes outside the accept cycle have no effect, because operands are latched.
- in_valid asserted in RUN or HOLD is ignored, not lost. The producer must hold it until in_ready is high.
- Reset in any state: abandon the transaction and return to the reset values on the next edge. No partial result is emitted.
- out_ready while out_valid=0 has no effect.
- cnt width is $clog2(NCHUNK) with a minimum of 1 bit. It never exceeds NCHUNK-1 and returns to 0 in IDLE.

Decomposition:
- Shared package gate_reducer_pkg holds:
  - mode constants MODE_AND..MODE_XNOR;
  - a base-op encoding (OP_AND, OP_OR, OP_XOR);
  - function mode_to_base(mode);
  - function mode_inverts(mode);
  - function mode_identity(mode);
  - function mode_reserved(mode);
  - FSM state encoding.
- One sub-module, chunk_reduce: purely combinational, parameter CHUNK. Inputs are a CHUNK-bit slice, acc_in, and base op; output is acc_out. It is instantiated once in the RUN datapath.

Test Plan (WIDTH=16, CHUNK=4 unless stated):
- AND with in_data=16'hFFFF: out_y=1, and out_valid rises exactly 4 edges after the accept edge. Repeat with 16'hFFFE: out_y=0.
- Mode coverage:
  - OR 16'h0000 gives 0; OR 16'h8000 gives 1.
  - XOR 16'h0001 gives 1; XNOR 16'h0003 gives 1.
  - NAND 16'hFFFF gives 0; NOR 16'h0000 gives 1.
  - out_err=0 throughout.
- Backpressure: hold out_ready=0 for 5 cycles in HOLD while toggling in_valid and in_data. out_valid stays 1, out_y is stable, in_ready stays 0, and no second result appears. After out_ready=1, in_ready=1 on the next cycle.
- Reserved mode 3'd7 with 16'hFFFF: after 4 cycles out_valid=1, out_y=0, out_err=1. The next valid request clears out_err.
- Assert rst for one edge during the 2nd RUN cycle: next cycle out_valid=0, in_ready=1, busy=0. A following AND of 16'hFFFF completes with out_y=1.
- Exhaustive check at WIDTH=4, CHUNK=1 and at WIDTH=4, CHUNK=4: all 16 in_data patterns in each of the 6 valid modes, compared against a reference model. Latency is 4 and 1 cycles respectively.
